baud_frame_gen: RTL and testbench
=================================

// Module: baud_frame_gen
// PURPOSE
//  Parametrised UART bit-timing engine; successor to the fixed 9600-baud, fixed-frame generator.
//  On trigger, times one serial frame with a runtime divisor and a runtime frame format.
//  Emits one bit_tick per bit: at bit start (TX mode) or mid-bit (RX sample mode).
//  Adds pause via enable and abort. Sits between the UART TX/RX shifters and sysclk.
// PARAMETERS
//  DIV_W       16     width of divisor input / internal bit counter
//  DEFAULT_DIV 10416  divisor used when div_load never pulsed (100 MHz / 9600)
// PORTS
//  sysclk     in   1      system clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  enable     in   1      1 = run; 0 in RUN = pause (counter/index hold, no ticks)
//  trigger    in   1      start frame; accepted only in IDLE with enable=1
//  abort      in   1      terminate frame; return to IDLE, no finish
//  div_load   in   1      1-cycle strobe: div_reg <= div
//  div        in   DIV_W  sysclk cycles per bit; values 0/1 clamp to 2
//  mode       in   1      0 = tick at bit start (TX), 1 = tick at mid-bit (RX)
//  data_bits  in   2      00=5, 01=6, 10=7, 11=8 data bits
//  parity_en  in   1      1 = one parity bit after data
//  stop2      in   1      0 = 1 stop bit, 1 = 2 stop bits
//  busy       out  1      1 while frame in progress (RUN)
//  bit_tick   out  1      1-cycle timing strobe for current bit
//  bit_index  out  4      bit number within frame (0 = start bit); 0 in IDLE
//  finish     out  1      1-cycle pulse when frame completes normally
// BEHAVIOUR
//  Reset: state=IDLE; busy, bit_tick, finish, bit_index = 0; cnt = 0; div_reg = DEFAULT_DIV.
//  Config latch: at trigger acceptance, latch P = max(div_reg,2), mode, nbits.
//   nbits = 1 + (5+data_bits) + parity_en + (stop2 ? 2 : 1); range 7..12.
//   Later config or div_load changes do not affect the running frame.
//  div_load is honoured in any state.
//  Latency: trigger accepted at cycle T -> busy=1, cnt=0, bit_index=0 at T+1.
//  FSM states: IDLE, RUN.
//  IDLE -> RUN: trigger & enable & ~abort.
//  RUN, enable=1, each cycle:
//   - cnt counts 0..P-1, then wraps to 0 and bit_index increments.
//   - Tick point: cnt==0 (mode 0) or cnt==P>>1 (mode 1).
//   - bit_tick = RUN & enable & (cnt == tick point); combinational from registered cnt.
//  RUN -> IDLE (normal): at cnt==P-1 with bit_index==nbits-1 and enable=1.
//   - Next cycle: busy=0, bit_index=0, finish=1 for exactly one cycle.
//   - Frame length: finish at T+1+nbits*P.
//  RUN, enable=0: cnt, bit_index hold; bit_tick=0; busy stays 1; frame stretches by paused cycles.
//  Abort:
//   - In RUN: next cycle IDLE, busy=0, bit_index=0, no finish, no further ticks.
//   - abort in the same cycle as the final wrap: abort wins, no finish.
//   - abort with trigger in IDLE: trigger ignored.
//  trigger while busy=1 is ignored (no restart, no queueing).
//  trigger in the cycle finish=1 (already IDLE) is accepted; back-to-back frames allowed.
//  Widths: cnt is DIV_W bits; comparisons are unsigned; P>>1 truncates (P=5 -> tick at cnt 2).
//  Reset asserted mid-frame: next cycle all outputs 0, IDLE, no finish.
// TESTING
//  T1 div=4, mode0, 8N1, trigger @0 -> busy 1..40; ticks @1,5,..,37 (idx 0..9); finish @41 only.
//  T2 div=5, mode1, 5 data+parity+2 stop (nbits=9), trigger @0 -> ticks @3,8,..,43; finish @46.
//  T3 as T1, enable=0 cycles 10-12 -> no tick @13; later ticks @16,20,..,40; finish @44.
//  T4 as T1, abort @10 -> busy 0 @11, bit_index 0, no finish/ticks; retrigger @12 -> busy @13.
//  T5 trigger pulses while busy ignored; trigger @41 (finish cycle) -> busy @42, tick @42.
//  T6 div=1 -> behaves as P=2 (8N1 finish @21); reset @15 mid-frame -> outputs 0 @16, no finish.

Source files
------------

// File: rtl/baud_frame_gen.sv
// baud_frame_gen: runtime-configurable UART bit-timing engine.
// One trigger times one serial frame (start, data, optional parity, stop bits)
// using a divisor and frame format captured when the frame starts. A single
// bit_tick per bit marks either the bit start (TX shifting) or the bit centre
// (RX sampling). enable pauses a running frame; abort drops it without finish.
module baud_frame_gen #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10416
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             trigger,
    input  logic             abort,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
    output logic             busy,
    output logic             bit_tick,
    output logic [3:0]       bit_index,
    output logic             finish
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    // Registered state.
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [3:0]       idx;
    logic             finish_q;
    logic [DIV_W-1:0] div_reg;

    // Frame configuration frozen at trigger acceptance.
    logic [DIV_W-1:0] per_reg;
    logic             mode_reg;
    logic [3:0]       nbits_reg;

    // Next-state values from the combinational FSM process.
    state_t           state_n;
    logic [DIV_W-1:0] cnt_n;
    logic [3:0]       idx_n;
    logic             finish_n;
    logic             latch_cfg;

    // Derived timing values.
    logic [DIV_W-1:0] per_clamped;
    logic [3:0]       nbits_new;
    logic [DIV_W-1:0] tick_point;
    logic [DIV_W-1:0] last_cnt;
    logic             accept;
    logic             bit_end;
    logic             frame_end;

    // Divisor register; a load strobe is honoured whether or not a frame runs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            div_reg <= DIV_RESET;
        end else if (div_load) begin
            div_reg <= div;
        end
    end

    // Divisors below two cannot give a distinct mid-bit point, so clamp them.
    always_comb begin
        per_clamped = (div_reg < DIV_MIN) ? DIV_MIN : div_reg;
    end

    // Frame length in bits: start + data (5..8) + optional parity + 1 or 2 stops.
    always_comb begin
        nbits_new = 4'd1 + (4'd5 + {2'b00, data_bits}) + {3'b000, parity_en}
                  + (stop2 ? 4'd2 : 4'd1);
    end

    // Timing values of the running frame, derived from the frozen configuration.
    always_comb begin
        tick_point = mode_reg ? (per_reg >> 1) : '0;
        last_cnt   = per_reg - CNT_ONE;
        accept     = (state == IDLE) && trigger && enable && !abort;
        bit_end    = (cnt == last_cnt);
        frame_end  = bit_end && (idx == (nbits_reg - 4'd1));
    end

    // Capture divisor, tick mode and frame length when a frame starts so that
    // later configuration changes only affect the next frame.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            per_reg   <= DIV_MIN;
            mode_reg  <= 1'b0;
            nbits_reg <= 4'd7;
        end else if (latch_cfg) begin
            per_reg   <= per_clamped;
            mode_reg  <= mode;
            nbits_reg <= nbits_new;
        end
    end

    // Next-state logic: start, pause, bit wrap, normal end and abort handling.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        finish_n  = 1'b0;
        latch_cfg = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = 4'd0;
                if (accept) begin
                    state_n   = RUN;
                    latch_cfg = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 4'd0;
                end else if (enable) begin
                    if (frame_end) begin
                        state_n  = IDLE;
                        cnt_n    = '0;
                        idx_n    = 4'd0;
                        finish_n = 1'b1;
                    end else if (bit_end) begin
                        cnt_n = '0;
                        idx_n = idx + 4'd1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = 4'd0;
            end
        endcase
    end

    // State, bit counter, bit index and finish pulse registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 4'd0;
            finish_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            finish_q <= finish_n;
        end
    end

    // Outputs; the tick is combinational from the registered counter and is
    // suppressed while paused.
    always_comb begin
        busy      = (state == RUN);
        bit_tick  = (state == RUN) && enable && (cnt == tick_point);
        bit_index = idx;
        finish    = finish_q;
    end

endmodule

// File: tb/tb_baud_frame_gen.sv
// tb_baud_frame_gen: scoreboard bench for baud_frame_gen.
// Stimulus pushes the expected tick/finish events (cycle, kind, bit index)
// into a queue; a negedge monitor pops and compares whenever the DUT shows
// bit_tick or finish. Level checks on busy/bit_index use checkOutput.
module tb_baud_frame_gen;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trigger;
    logic        abort;
    logic        div_load;
    logic [15:0] div;
    logic        mode;
    logic [1:0]  data_bits;
    logic        parity_en;
    logic        stop2;
    logic        busy;
    logic        bit_tick;
    logic [3:0]  bit_index;
    logic        finish;

    typedef struct {
        int cyc;
        bit fin;
        int idx;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;

    baud_frame_gen #(
        .DIV_W(16),
        .DEFAULT_DIV(10416)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .enable(enable),
        .trigger(trigger),
        .abort(abort),
        .div_load(div_load),
        .div(div),
        .mode(mode),
        .data_bits(data_bits),
        .parity_en(parity_en),
        .stop2(stop2),
        .busy(busy),
        .bit_tick(bit_tick),
        .bit_index(bit_index),
        .finish(finish)
    );

    // 10-unit clock period.
    always #5 sysclk = ~sysclk;

    // Cycle c is the interval that starts at the c-th rising edge.
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_event(input bit fin, input int idx);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL unexpected_%s: got event at cycle %0d idx %0d, expected none",
                     fin ? "finish" : "tick", cyc, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.fin == fin && (fin || e.idx == idx)) begin
                n_pass++;
            end else begin
                $display("[TB] FAIL event: got %s at cycle %0d idx %0d, expected %s at cycle %0d idx %0d",
                         fin ? "finish" : "tick", cyc, idx, e.fin ? "finish" : "tick", e.cyc, e.idx);
            end
        end
    endtask

    // Monitor: compare every presented tick/finish against the scoreboard.
    always @(negedge sysclk) begin
        if (bit_tick === 1'b1) check_event(1'b0, int'(bit_index));
        if (finish === 1'b1) check_event(1'b1, 0);
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic go_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic sample_at(input int c);
        go_cycle(c);
        #3;
    endtask

    task automatic push_ticks(input int first, input int period, input int count, input int first_idx);
        for (int k = 0; k < count; k++) begin
            exp_q.push_back('{cyc: first + k * period, fin: 1'b0, idx: first_idx + k});
        end
    endtask

    task automatic push_finish(input int c);
        exp_q.push_back('{cyc: c, fin: 1'b1, idx: 0});
    endtask

    // Load a divisor and set the frame format for the next trigger.
    task automatic applyStimulus(input logic [15:0] d, input logic m, input logic [1:0] db,
                                 input logic pe, input logic s2);
        div       = d;
        mode      = m;
        data_bits = db;
        parity_en = pe;
        stop2     = s2;
        div_load  = 1'b1;
        step();
        div_load  = 1'b0;
    endtask

    task automatic fire(output int t0);
        t0      = cyc;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    // Wait (bounded) for all expected events, then allow time for strays.
    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        repeat (4) step();
        checkOutput({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int t0;
        int t1;
        reset     = 1'b1;
        enable    = 1'b1;
        trigger   = 1'b0;
        abort     = 1'b0;
        div_load  = 1'b0;
        div       = 16'd0;
        mode      = 1'b0;
        data_bits = 2'b11;
        parity_en = 1'b0;
        stop2     = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        sample_at(cyc);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_tick", int'(bit_tick), 0);
        checkOutput("reset_index", int'(bit_index), 0);
        checkOutput("reset_finish", int'(finish), 0);

        // Default divisor 10416, mid-bit mode: first tick 5208 cycles in.
        $display("[TB] default divisor");
        step();
        mode = 1'b1;
        fire(t0);
        push_ticks(t0 + 1 + 5208, 0, 1, 0);
        sample_at(t0 + 1);
        checkOutput("t0_busy_start", int'(busy), 1);
        checkOutput("t0_index_start", int'(bit_index), 0);
        go_cycle(t0 + 5215);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample_at(t0 + 5216);
        checkOutput("t0_busy_abort", int'(busy), 0);
        drain("t0", 10);

        // T1: div 4, tick at bit start, 8N1.
        $display("[TB] T1 8N1 div 4");
        applyStimulus(16'd4, 1'b0, 2'b11, 1'b0, 1'b0);
        fire(t0);
        push_ticks(t0 + 1, 4, 10, 0);
        push_finish(t0 + 41);
        sample_at(t0 + 1);
        checkOutput("t1_busy_first", int'(busy), 1);
        sample_at(t0 + 40);
        checkOutput("t1_busy_last", int'(busy), 1);
        checkOutput("t1_index_last", int'(bit_index), 9);
        sample_at(t0 + 41);
        checkOutput("t1_busy_done", int'(busy), 0);
        checkOutput("t1_index_done", int'(bit_index), 0);
        drain("t1", 10);

        // T2: div 5 mid-bit, 5 data + parity + 2 stop; config changes mid-frame ignored.
        $display("[TB] T2 5E2 div 5 mid-bit");
        applyStimulus(16'd5, 1'b1, 2'b00, 1'b1, 1'b1);
        fire(t0);
        push_ticks(t0 + 3, 5, 9, 0);
        push_finish(t0 + 46);
        go_cycle(t0 + 10);
        applyStimulus(16'd4, 1'b0, 2'b11, 1'b0, 1'b0);
        sample_at(t0 + 20);
        checkOutput("t2_index_mid", int'(bit_index), 3);
        drain("t2", 60);

        // T3: pause for cycles 10..12 stretches the frame by three cycles.
        $display("[TB] T3 pause");
        fire(t0);
        push_ticks(t0 + 1, 4, 3, 0);
        push_ticks(t0 + 16, 4, 7, 3);
        push_finish(t0 + 44);
        go_cycle(t0 + 10);
        enable = 1'b0;
        sample_at(t0 + 11);
        checkOutput("t3_busy_paused", int'(busy), 1);
        checkOutput("t3_index_paused", int'(bit_index), 2);
        go_cycle(t0 + 13);
        enable = 1'b1;
        drain("t3", 60);

        // T4: abort mid-frame, immediate retrigger, abort on final wrap, abort+trigger in IDLE.
        $display("[TB] T4 abort");
        fire(t0);
        push_ticks(t0 + 1, 4, 3, 0);
        go_cycle(t0 + 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample_at(t0 + 11);
        checkOutput("t4_busy_abort", int'(busy), 0);
        checkOutput("t4_index_abort", int'(bit_index), 0);
        go_cycle(t0 + 12);
        fire(t1);
        push_ticks(t1 + 1, 4, 10, 0);
        push_finish(t1 + 41);
        sample_at(t1 + 1);
        checkOutput("t4_busy_retrig", int'(busy), 1);
        drain("t4a", 60);
        fire(t0);
        push_ticks(t0 + 1, 4, 10, 0);
        go_cycle(t0 + 40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample_at(t0 + 41);
        checkOutput("t4_finish_abort_wrap", int'(finish), 0);
        checkOutput("t4_busy_abort_wrap", int'(busy), 0);
        step();
        abort   = 1'b1;
        trigger = 1'b1;
        step();
        abort   = 1'b0;
        trigger = 1'b0;
        #3;
        checkOutput("t4_busy_abort_trig", int'(busy), 0);
        drain("t4b", 10);

        // T5: triggers while busy ignored; trigger in the finish cycle accepted.
        $display("[TB] T5 back-to-back");
        fire(t0);
        push_ticks(t0 + 1, 4, 10, 0);
        push_finish(t0 + 41);
        go_cycle(t0 + 5);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        go_cycle(t0 + 20);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        go_cycle(t0 + 41);
        fire(t1);
        push_ticks(t1 + 1, 4, 10, 0);
        push_finish(t1 + 41);
        sample_at(t1 + 1);
        checkOutput("t5_busy_b2b", int'(busy), 1);
        drain("t5", 60);

        // T6: divisor 1 clamps to 2; reset mid-frame clears everything.
        $display("[TB] T6 clamp and reset");
        applyStimulus(16'd1, 1'b0, 2'b11, 1'b0, 1'b0);
        fire(t0);
        push_ticks(t0 + 1, 2, 10, 0);
        push_finish(t0 + 21);
        drain("t6a", 30);
        fire(t1);
        push_ticks(t1 + 1, 2, 8, 0);
        go_cycle(t1 + 15);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sample_at(t1 + 16);
        checkOutput("t6_busy_reset", int'(busy), 0);
        checkOutput("t6_tick_reset", int'(bit_tick), 0);
        checkOutput("t6_index_reset", int'(bit_index), 0);
        checkOutput("t6_finish_reset", int'(finish), 0);
        drain("t6b", 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
